gpreg_wb_sched: RTL and testbench
=================================

# gpreg_wb_sched

Write-back scheduler and read-hazard guard for the 8×32 general-purpose register file. It merges two write-back sources onto the register file's single write port (MemInstruction = 2'b11 with SelZ/MemData):

- the ALU result path, which is unbuffered;
- the memory-load path, which goes through a 2-entry FIFO.

Arbitration between them is round-robin. The block also sequences operand reads on SelX/SelY and stalls any read that targets a register with a pending write.

## Interface
Parameters:
- DATA_W, 32, register data width
- REG_AW, 3, register index width (8 registers)
- MEM_FIFO_DEPTH, 2, memory write-back FIFO entries (power of two, ≥2)

Ports (clock and reset first):
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- alu_wr_valid  in  1  ALU write-back request
- alu_wr_sel  in  REG_AW  ALU destination register
- alu_wr_data  in  DATA_W  ALU result
- alu_wr_ready  out  1  combinational; high when the ALU request is granted this cycle
- mem_wr_valid  in  1  memory-load write-back request
- mem_wr_sel  in  REG_AW  load destination register
- mem_wr_data  in  DATA_W  load data
- mem_wr_ready  out  1  combinational; equals !fifo_full
- rd_valid  in  1  operand read request
- rd_x_sel  in  REG_AW  operand A register
- rd_y_sel  in  REG_AW  operand B register
- rd_stall  out  1  combinational; read hazard, request not accepted
- rd_ack  out  1  registered; one-cycle pulse, read accepted previous cycle
- rf_sel_x  out  REG_AW  to register file SelX
- rf_sel_y  out  REG_AW  to register file SelY
- rf_sel_z  out  REG_AW  to register file SelZ
- rf_mem_instr  out  2  to register file MemInstruction (2'b11 = write, 2'b00 = idle)
- rf_mem_data  out  DATA_W  to register file MemData

## Operation
- **Memory path:** every accepted mem request (mem_wr_valid && mem_wr_ready) enqueues {sel, data}. There is no bypass; a load issues at the earliest one cycle after acceptance.
- **Arbitration:** each cycle at most one write is granted, drawn from the ALU request and the FIFO head.
  - If only one source is present, it wins.
  - If both are present, the winner is the source not granted last; last_grant updates only when both contended.
  - Reset sets last_grant = MEM, so the ALU wins the first contention.
- **Issue stage:** the granted write is registered at the next edge as rf_mem_instr = 2'b11, rf_sel_z = sel, rf_mem_data = data. With no grant, rf_mem_instr = 2'b00 and rf_sel_z/rf_mem_data hold their values.
- **FIFO:**
  - Dequeue on a FIFO grant.
  - Enqueue and dequeue in the same cycle are allowed when not full; the count is unchanged.
  - When full, mem_wr_ready = 0 even if a dequeue occurs that cycle.
- **Hazard:** rd_stall = rd_valid && (rd_x_sel or rd_y_sel) matches any of the following:
  - any valid FIFO entry;
  - alu_wr_sel while alu_wr_valid;
  - rf_sel_z while rf_mem_instr == 2'b11 (the in-flight write, because the register file returns old data on a same-edge read/write).
- **Read accept:** when rd_valid && !rd_stall:
  - rf_sel_x/rf_sel_y load rd_x_sel/rd_y_sel at the next edge;
  - rd_ack pulses high for one cycle.
  - Otherwise rf_sel_x/rf_sel_y hold.
- **Same-register writes:** writes to the same register from both sources are committed in grant order. Upstream guarantees ordering if it matters.

## Timing
- **Reset values:** rf_mem_instr = 2'b00, rf_sel_x = rf_sel_y = rf_sel_z = 0, rf_mem_data = 0, rd_ack = 0. The FIFO is empty, so mem_wr_ready = 1 in the cycle after reset deasserts.
- **Reset mid-operation:** FIFO contents and any in-flight write are discarded. rf_mem_instr is 2'b00 at the first edge with rst high; no partial write is issued.
- **ALU write latency:** request granted in cycle N, rf_mem_instr = 2'b11 during N+1, register file updated at the end of N+1.
- **Memory write latency:** accepted in cycle N, earliest grant N+1, on port during N+2.
- **Read latency:** accepted in cycle N, rd_ack and rf_sel_x/y during N+1, register file A/B valid during N+2.
- **Throughput:** one write per cycle and one read per cycle, concurrently.
- **Sustained contention:** writes alternate ALU, MEM, ALU, MEM. alu_wr_ready is low on alternate cycles; the ALU must hold valid and data until ready.

## Test plan
- **Single ALU write:** after reset, ALU writes 0xDEADBEEF to r3 in cycle N → rf_mem_instr = 11, rf_sel_z = 3, rf_mem_data = 0xDEADBEEF in N+1 only; 00 in N+2.
- **FIFO full:** three back-to-back mem writes (r1, r2, r4) with the ALU busy holding valid → mem_wr_ready drops after two accepts. Writes are issued in order r1, r2, r4, interleaved with the ALU write round-robin.
- **Contention:** ALU (r5, 0x5) and FIFO (r6, 0x6) both continuously valid from reset → issue order ALU, MEM, ALU, MEM; alu_wr_ready = 1, 0, 1, 0.
- **Hazard stall:** ALU write to r2 in flight, then a read of x = r2 → rd_stall high through the issue cycle. The read is accepted the cycle after rf_mem_instr returns to 00, and A returns the new value.
- **Reset mid-operation:** two FIFO entries pending plus an in-flight write, rst asserted for one cycle → rf_mem_instr = 00 during reset and after, no further writes, mem_wr_ready = 1.
- **Simultaneous enqueue/dequeue:** FIFO at one entry with ALU idle, and a new mem accept in the same cycle → count stays 1 and entries issue in FIFO order.

Source files
------------

// File: rtl/gpreg_wb_sched_if.sv
// Bus bundle between the write-back scheduler and its neighbours: ALU and load
// write-back requests, operand read requests, and the register-file control port.
interface gpreg_wb_sched_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 3
);
   logic              alu_wr_valid;
   logic [REG_AW-1:0] alu_wr_sel;
   logic [DATA_W-1:0] alu_wr_data;
   logic              alu_wr_ready;
   logic              mem_wr_valid;
   logic [REG_AW-1:0] mem_wr_sel;
   logic [DATA_W-1:0] mem_wr_data;
   logic              mem_wr_ready;
   logic              rd_valid;
   logic [REG_AW-1:0] rd_x_sel;
   logic [REG_AW-1:0] rd_y_sel;
   logic              rd_stall;
   logic              rd_ack;
   logic [REG_AW-1:0] rf_sel_x;
   logic [REG_AW-1:0] rf_sel_y;
   logic [REG_AW-1:0] rf_sel_z;
   logic [1:0]        rf_mem_instr;
   logic [DATA_W-1:0] rf_mem_data;

   modport slave (
      input  alu_wr_valid, alu_wr_sel, alu_wr_data,
      output alu_wr_ready,
      input  mem_wr_valid, mem_wr_sel, mem_wr_data,
      output mem_wr_ready,
      input  rd_valid, rd_x_sel, rd_y_sel,
      output rd_stall, rd_ack, rf_sel_x, rf_sel_y, rf_sel_z, rf_mem_instr, rf_mem_data
   );

   modport master (
      output alu_wr_valid, alu_wr_sel, alu_wr_data,
      input  alu_wr_ready,
      output mem_wr_valid, mem_wr_sel, mem_wr_data,
      input  mem_wr_ready,
      output rd_valid, rd_x_sel, rd_y_sel,
      input  rd_stall, rd_ack, rf_sel_x, rf_sel_y, rf_sel_z, rf_mem_instr, rf_mem_data
   );
endinterface

// File: rtl/gpreg_wb_sched.sv
// Merges ALU and FIFO-buffered load write-backs onto the single register-file write
// port with round-robin arbitration, and stalls operand reads hitting pending writes.
module gpreg_wb_sched #(
   parameter int DATA_W         = 32,
   parameter int REG_AW         = 3,
   parameter int MEM_FIFO_DEPTH = 2
) (
   input logic             clk,
   input logic             rst,
   gpreg_wb_sched_if.slave bus
);
   localparam int PTR_W = $clog2(MEM_FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {GNT_ALU = 1'b0, GNT_MEM = 1'b1} grant_e;

   grant_e                    r_last_grant;
   logic [REG_AW-1:0]         r_fifo_sel  [MEM_FIFO_DEPTH];
   logic [DATA_W-1:0]         r_fifo_data [MEM_FIFO_DEPTH];
   logic [MEM_FIFO_DEPTH-1:0] r_fifo_vld;
   logic [PTR_W-1:0]          r_wr_ptr;
   logic [PTR_W-1:0]          r_rd_ptr;
   logic [CNT_W-1:0]          r_count;
   logic [1:0]                r_rf_mem_instr;
   logic [REG_AW-1:0]         r_rf_sel_z;
   logic [DATA_W-1:0]         r_rf_mem_data;
   logic [REG_AW-1:0]         r_rf_sel_x;
   logic [REG_AW-1:0]         r_rf_sel_y;
   logic                      r_rd_ack;

   logic                      w_full;
   logic                      w_mem_avail;
   logic                      w_enq;
   logic                      w_grant_alu;
   logic                      w_grant_mem;
   logic [MEM_FIFO_DEPTH-1:0] w_enq_mask;
   logic [MEM_FIFO_DEPTH-1:0] w_deq_mask;
   logic                      w_inflight;
   logic                      w_haz_x;
   logic                      w_haz_y;
   logic                      w_stall;
   logic                      w_rd_accept;

   // Arbitration: last_grant only breaks ties, so a lone source always wins.
   always_comb begin
      w_full      = (r_count == CNT_W'(MEM_FIFO_DEPTH));
      w_mem_avail = (r_count != {CNT_W{1'b0}});
      w_enq       = bus.mem_wr_valid && !w_full;
      w_grant_alu = bus.alu_wr_valid && (!w_mem_avail || (r_last_grant == GNT_MEM));
      w_grant_mem = w_mem_avail && (!bus.alu_wr_valid || (r_last_grant == GNT_ALU));
      w_enq_mask  = w_enq       ? (MEM_FIFO_DEPTH'(1) << r_wr_ptr) : {MEM_FIFO_DEPTH{1'b0}};
      w_deq_mask  = w_grant_mem ? (MEM_FIFO_DEPTH'(1) << r_rd_ptr) : {MEM_FIFO_DEPTH{1'b0}};
   end

   // The register file returns old data on a same-edge read/write, so the issuing write also blocks.
   always_comb begin
      w_inflight = (r_rf_mem_instr == 2'b11);
      w_haz_x    = (bus.alu_wr_valid && (bus.alu_wr_sel == bus.rd_x_sel)) ||
                   (w_inflight && (r_rf_sel_z == bus.rd_x_sel));
      w_haz_y    = (bus.alu_wr_valid && (bus.alu_wr_sel == bus.rd_y_sel)) ||
                   (w_inflight && (r_rf_sel_z == bus.rd_y_sel));
      for (int i = 0; i < MEM_FIFO_DEPTH; i++) begin
         w_haz_x = w_haz_x | (r_fifo_vld[i] && (r_fifo_sel[i] == bus.rd_x_sel));
         w_haz_y = w_haz_y | (r_fifo_vld[i] && (r_fifo_sel[i] == bus.rd_y_sel));
      end
      w_stall     = bus.rd_valid && (w_haz_x || w_haz_y);
      w_rd_accept = bus.rd_valid && !w_stall;
   end

   // Load write-back FIFO
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= {PTR_W{1'b0}};
         r_rd_ptr   <= {PTR_W{1'b0}};
         r_count    <= {CNT_W{1'b0}};
         r_fifo_vld <= {MEM_FIFO_DEPTH{1'b0}};
      end else begin
         if (w_enq) begin
            r_fifo_sel[r_wr_ptr]  <= bus.mem_wr_sel;
            r_fifo_data[r_wr_ptr] <= bus.mem_wr_data;
            r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
         end
         if (w_grant_mem) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_fifo_vld <= (r_fifo_vld & ~w_deq_mask) | w_enq_mask;
         r_count    <= r_count + CNT_W'(w_enq) - CNT_W'(w_grant_mem);
      end
   end

   // Write issue stage and round-robin pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rf_mem_instr <= 2'b00;
         r_rf_sel_z     <= {REG_AW{1'b0}};
         r_rf_mem_data  <= {DATA_W{1'b0}};
         r_last_grant   <= GNT_MEM;
      end else begin
         if (w_grant_alu) begin
            r_rf_mem_instr <= 2'b11;
            r_rf_sel_z     <= bus.alu_wr_sel;
            r_rf_mem_data  <= bus.alu_wr_data;
         end else if (w_grant_mem) begin
            r_rf_mem_instr <= 2'b11;
            r_rf_sel_z     <= r_fifo_sel[r_rd_ptr];
            r_rf_mem_data  <= r_fifo_data[r_rd_ptr];
         end else begin
            r_rf_mem_instr <= 2'b00;
         end
         if (bus.alu_wr_valid && w_mem_avail) begin
            r_last_grant <= w_grant_alu ? GNT_ALU : GNT_MEM;
         end
      end
   end

   // Operand read stage
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rf_sel_x <= {REG_AW{1'b0}};
         r_rf_sel_y <= {REG_AW{1'b0}};
         r_rd_ack   <= 1'b0;
      end else begin
         r_rd_ack <= w_rd_accept;
         if (w_rd_accept) begin
            r_rf_sel_x <= bus.rd_x_sel;
            r_rf_sel_y <= bus.rd_y_sel;
         end
      end
   end

   assign bus.alu_wr_ready = w_grant_alu;
   assign bus.mem_wr_ready = !w_full;
   assign bus.rd_stall     = w_stall;
   assign bus.rd_ack       = r_rd_ack;
   assign bus.rf_sel_x     = r_rf_sel_x;
   assign bus.rf_sel_y     = r_rf_sel_y;
   assign bus.rf_sel_z     = r_rf_sel_z;
   assign bus.rf_mem_instr = r_rf_mem_instr;
   assign bus.rf_mem_data  = r_rf_mem_data;
endmodule

// File: tb/tb_gpreg_wb_sched.sv
// Directed bench for gpreg_wb_sched: stimulus pushes expected writes/reads into queues,
// a negedge monitor pops and compares whenever the port writes or rd_ack pulses.
module tb_gpreg_wb_sched;
   typedef struct packed {
      logic [2:0]  sel;
      logic [31:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   wr_t  wr_q[$];
   logic [5:0] rd_q[$];
   wr_t  exp_w;
   logic [5:0] exp_r;

   gpreg_wb_sched_if #(.DATA_W(32), .REG_AW(3)) bus ();

   gpreg_wb_sched #(.DATA_W(32), .REG_AW(3), .MEM_FIFO_DEPTH(2)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Scoreboard monitor for the write port and the read acknowledge
   always @(negedge clk) begin
      if (bus.rf_mem_instr == 2'b11) begin
         if (wr_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_write: sel=%0d data=%0h, expected no write", bus.rf_sel_z, bus.rf_mem_data);
         end else begin
            exp_w = wr_q.pop_front();
            check("wr_sel", 64'(bus.rf_sel_z), 64'(exp_w.sel));
            check("wr_data", 64'(bus.rf_mem_data), 64'(exp_w.data));
         end
      end else if (!rst) begin
         check("wr_instr_idle", 64'(bus.rf_mem_instr), 64'(2'b00));
      end
      if (bus.rd_ack === 1'b1) begin
         if (rd_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_ack: x=%0d y=%0d, expected no ack", bus.rf_sel_x, bus.rf_sel_y);
         end else begin
            exp_r = rd_q.pop_front();
            check("rd_sel_x", 64'(bus.rf_sel_x), 64'(exp_r[5:3]));
            check("rd_sel_y", 64'(bus.rf_sel_y), 64'(exp_r[2:0]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.alu_wr_valid = 1'b0; bus.alu_wr_sel = 3'd0; bus.alu_wr_data = 32'h0;
      bus.mem_wr_valid = 1'b0; bus.mem_wr_sel = 3'd0; bus.mem_wr_data = 32'h0;
      bus.rd_valid     = 1'b0; bus.rd_x_sel   = 3'd0; bus.rd_y_sel    = 3'd0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // One cycle of write stimulus with the expected combinational ready values
   task automatic cyc(input logic av, input logic [2:0] as, input logic [31:0] ad,
                      input logic mv, input logic [2:0] ms, input logic [31:0] md,
                      input logic ear, input logic emr, input string nm);
      tick();
      bus.alu_wr_valid = av; bus.alu_wr_sel = as; bus.alu_wr_data = ad;
      bus.mem_wr_valid = mv; bus.mem_wr_sel = ms; bus.mem_wr_data = md;
      #1;
      check({nm, "_alu_rdy"}, 64'(bus.alu_wr_ready), 64'(ear));
      check({nm, "_mem_rdy"}, 64'(bus.mem_wr_ready), 64'(emr));
   endtask

   task automatic wait_drain(input string nm);
      int n = 0;
      tick();
      idle();
      while ((wr_q.size() != 0 || rd_q.size() != 0) && n < 20) begin
         tick();
         n++;
      end
      if (wr_q.size() != 0 || rd_q.size() != 0) begin
         total++; bad++;
         $display("FAIL %s_drain: %0d writes %0d reads outstanding, expected 0", nm, wr_q.size(), rd_q.size());
         wr_q.delete();
         rd_q.delete();
      end
      repeat (3) tick();
   endtask

   initial begin
      idle();
      rst = 1'b1;
      repeat (3) tick();
      check("rst_instr", 64'(bus.rf_mem_instr), 64'(2'b00));
      check("rst_sel_x", 64'(bus.rf_sel_x), 64'(3'd0));
      check("rst_sel_y", 64'(bus.rf_sel_y), 64'(3'd0));
      check("rst_sel_z", 64'(bus.rf_sel_z), 64'(3'd0));
      check("rst_data", 64'(bus.rf_mem_data), 64'(32'h0));
      check("rst_ack", 64'(bus.rd_ack), 64'(1'b0));
      rst = 1'b0;
      tick();
      check("rst_mem_rdy", 64'(bus.mem_wr_ready), 64'(1'b1));

      // Single ALU write: on port for exactly one cycle, then data/sel hold
      do_reset();
      wr_q.push_back('{3'd3, 32'hDEADBEEF});
      cyc(1'b1, 3'd3, 32'hDEADBEEF, 1'b0, 3'd0, 32'h0, 1'b1, 1'b1, "t1");
      tick();
      bus.alu_wr_valid = 1'b0;
      #1 check("t1_instr_n1", 64'(bus.rf_mem_instr), 64'(2'b11));
      tick();
      #1 check("t1_instr_n2", 64'(bus.rf_mem_instr), 64'(2'b00));
      check("t1_hold_data", 64'(bus.rf_mem_data), 64'(32'hDEADBEEF));
      check("t1_hold_sel", 64'(bus.rf_sel_z), 64'(3'd3));
      wait_drain("t1");

      // FIFO full with the ALU streaming: order A0 A1 r1 A2 r2 r4
      do_reset();
      wr_q.push_back('{3'd7, 32'hA0});
      wr_q.push_back('{3'd7, 32'hA1});
      wr_q.push_back('{3'd1, 32'h11});
      wr_q.push_back('{3'd7, 32'hA2});
      wr_q.push_back('{3'd2, 32'h22});
      wr_q.push_back('{3'd4, 32'h44});
      cyc(1'b1, 3'd7, 32'hA0, 1'b1, 3'd1, 32'h11, 1'b1, 1'b1, "t2_c0");
      cyc(1'b1, 3'd7, 32'hA1, 1'b1, 3'd2, 32'h22, 1'b1, 1'b1, "t2_c1");
      cyc(1'b1, 3'd7, 32'hA2, 1'b1, 3'd4, 32'h44, 1'b0, 1'b0, "t2_c2");
      cyc(1'b1, 3'd7, 32'hA2, 1'b1, 3'd4, 32'h44, 1'b1, 1'b1, "t2_c3");
      cyc(1'b0, 3'd0, 32'h0,  1'b0, 3'd0, 32'h0,  1'b0, 1'b0, "t2_c4");
      cyc(1'b0, 3'd0, 32'h0,  1'b0, 3'd0, 32'h0,  1'b0, 1'b1, "t2_c5");
      wait_drain("t2");

      // Sustained contention: ALU r5 vs FIFO r6 alternate, ALU first
      do_reset();
      cyc(1'b0, 3'd0, 32'h0, 1'b1, 3'd6, 32'h6, 1'b0, 1'b1, "t3_c0");
      for (int i = 1; i <= 6; i++) begin
         if (i % 2 == 1) wr_q.push_back('{3'd5, 32'h5});
         else            wr_q.push_back('{3'd6, 32'h6});
         cyc(1'b1, 3'd5, 32'h5, 1'b1, 3'd6, 32'h6, (i % 2 == 1), (i % 2 == 1), "t3_c");
      end
      wr_q.push_back('{3'd6, 32'h6});
      cyc(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b1, "t3_c7");
      wait_drain("t3");

      // Hazard stall on an ALU write to r2, then a back-to-back clean read
      do_reset();
      tick();
      wr_q.push_back('{3'd2, 32'h22});
      bus.alu_wr_valid = 1'b1; bus.alu_wr_sel = 3'd2; bus.alu_wr_data = 32'h22;
      bus.rd_valid = 1'b1; bus.rd_x_sel = 3'd2; bus.rd_y_sel = 3'd0;
      #1 check("t4_stall_req", 64'(bus.rd_stall), 64'(1'b1));
      check("t4_alu_rdy", 64'(bus.alu_wr_ready), 64'(1'b1));
      tick();
      bus.alu_wr_valid = 1'b0;
      #1 check("t4_stall_issue", 64'(bus.rd_stall), 64'(1'b1));
      tick();
      #1 check("t4_stall_clear", 64'(bus.rd_stall), 64'(1'b0));
      rd_q.push_back({3'd2, 3'd0});
      tick();
      bus.rd_x_sel = 3'd1; bus.rd_y_sel = 3'd7;
      #1 check("t4_stall_clean", 64'(bus.rd_stall), 64'(1'b0));
      rd_q.push_back({3'd1, 3'd7});
      tick();
      bus.rd_valid = 1'b0;
      wait_drain("t4");

      // Reset mid-operation: two FIFO entries and an issuing write are dropped
      do_reset();
      cyc(1'b0, 3'd0, 32'h0,  1'b1, 3'd1, 32'h11, 1'b0, 1'b1, "t5_ca");
      wr_q.push_back('{3'd3, 32'h33});
      cyc(1'b1, 3'd3, 32'h33, 1'b1, 3'd2, 32'h22, 1'b1, 1'b1, "t5_cb");
      tick();
      rst = 1'b1;
      bus.alu_wr_valid = 1'b1; bus.alu_wr_sel = 3'd5; bus.alu_wr_data = 32'h55;
      bus.mem_wr_valid = 1'b0;
      tick();
      rst = 1'b0;
      idle();
      #1 check("t5_instr", 64'(bus.rf_mem_instr), 64'(2'b00));
      check("t5_sel_z", 64'(bus.rf_sel_z), 64'(3'd0));
      check("t5_data", 64'(bus.rf_mem_data), 64'(32'h0));
      check("t5_mem_rdy", 64'(bus.mem_wr_ready), 64'(1'b1));
      tick();
      #1 check("t5_instr_after", 64'(bus.rf_mem_instr), 64'(2'b00));
      wait_drain("t5");

      // Simultaneous enqueue/dequeue at one entry, then a read blocked by the FIFO entry
      do_reset();
      wr_q.push_back('{3'd1, 32'h101});
      wr_q.push_back('{3'd2, 32'h102});
      cyc(1'b0, 3'd0, 32'h0, 1'b1, 3'd1, 32'h101, 1'b0, 1'b1, "t6_c0");
      cyc(1'b0, 3'd0, 32'h0, 1'b1, 3'd2, 32'h102, 1'b0, 1'b1, "t6_c1");
      tick();
      bus.mem_wr_valid = 1'b0;
      bus.rd_valid = 1'b1; bus.rd_x_sel = 3'd6; bus.rd_y_sel = 3'd2;
      #1 check("t6_stall_fifo", 64'(bus.rd_stall), 64'(1'b1));
      check("t6_mem_rdy_c2", 64'(bus.mem_wr_ready), 64'(1'b1));
      tick();
      #1 check("t6_stall_issue", 64'(bus.rd_stall), 64'(1'b1));
      tick();
      #1 check("t6_stall_clear", 64'(bus.rd_stall), 64'(1'b0));
      rd_q.push_back({3'd6, 3'd2});
      tick();
      bus.rd_valid = 1'b0;
      wait_drain("t6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
